// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard unit: forwarding, load-use/branch stall-flush, memory-wait FSM, watchdog (optional HAZARD_PERFCNT_EN counters)
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  RA1D,
    input  logic [3:0]  RA2D,
    input  logic [3:0]  RA1E,
    input  logic [3:0]  RA2E,
    input  logic [3:0]  WA3E,
    input  logic [3:0]  WA3M,
    input  logic [3:0]  WA3W,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        PCSrcD,
    input  logic        PCSrcE,
    input  logic        PCSrcM,
    input  logic        PCSrcW,
    input  logic        BranchTakenE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemTimeout,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
);

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wd_cnt;
    logic       ld_stall;
    logic       pc_wr_pending;
    logic       mem_hold;

    // Register 15 is the PC and is never forwarded; M-stage result has priority over W-stage.
    function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                           input logic       rw_m,
                                           input logic [3:0] wa_m,
                                           input logic       rw_w,
                                           input logic [3:0] wa_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (ra != 4'hF) begin
            if (rw_m && (ra == wa_m))
                sel = 2'b10;
            else if (rw_w && (ra == wa_w))
                sel = 2'b01;
        end
        return sel;
    endfunction

    assign ld_stall      = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
    assign pc_wr_pending = PCSrcD || PCSrcE || PCSrcM;
    // Full freeze covers the cycle the wait is first seen and every waiting cycle until ready.
    assign mem_hold      = MemReqM && !MemReadyM && ((state == RUN) || (state == MEMWAIT));

    // State register: reset always lands in RUN, abandoning any pending memory wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // Next state: enter MEMWAIT on an unfinished access, leave on the first ready cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (MemReqM && !MemReadyM) state_nxt = MEMWAIT;
            MEMWAIT: if (MemReadyM)             state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Outputs: reset forces flushes, a memory wait freezes everything, otherwise hazard equations.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (!reset_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
            ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
            if (mem_hold || ((state == MEMWAIT) && !MemReadyM)) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = ld_stall || pc_wr_pending;
                StallD = ld_stall;
                FlushD = pc_wr_pending || PCSrcW || BranchTakenE;
                FlushE = ld_stall || BranchTakenE;
            end
        end
    end

    // Watchdog: counts waiting cycles, saturates at 255 and latches the timeout until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt     <= 8'd0;
            MemTimeout <= 1'b0;
        end else if (state == MEMWAIT) begin
            if (wd_cnt != 8'hFF)
                wd_cnt <= wd_cnt + 8'd1;
            if (wd_cnt >= 8'hFE)
                MemTimeout <= 1'b1;
        end else begin
            wd_cnt <= 8'd0;
        end
    end

`ifdef HAZARD_PERFCNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Performance counters: free-running 32-bit wrap on stall and front-end flush cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (StallF || StallD || StallE || StallM)
                stall_cnt <= stall_cnt + 32'd1;
            if (FlushD || FlushE)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign StallCycles = stall_cnt;
    assign FlushCount  = flush_cnt;
`else
    assign StallCycles = 32'd0;
    assign FlushCount  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk;
    logic        reset_n;
    logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic        RegWriteM, RegWriteW, MemtoRegE;
    logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic        MemReqM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic        MemTimeout;
    logic [31:0] StallCycles, FlushCount;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemTimeout(MemTimeout), .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       rwm, rww, m2re, pcd, pce, pcm, pcw, bte;
        logic [1:0] fae, fbe;
        logic       sf, sd, fd, fe;
    } vec_t;

    vec_t vecs [15];

    // {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    function automatic logic [10:0] ctl_bus();
        return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
        WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
        PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
        BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e;
        WA3E = v.wa3e; WA3M = v.wa3m; WA3W = v.wa3w;
        RegWriteM = v.rwm; RegWriteW = v.rww; MemtoRegE = v.m2re;
        PCSrcD = v.pcd; PCSrcE = v.pce; PCSrcM = v.pcm; PCSrcW = v.pcw;
        BranchTakenE = v.bte; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        set_idle();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    localparam logic [10:0] HOLD_BUS  = 11'b00_00_1111_001;
    localparam logic [10:0] IDLE_BUS  = 11'b00_00_0000_000;
    localparam logic [10:0] RESET_BUS = 11'b00_00_0000_111;

    logic [31:0] exp_stall;
    logic [31:0] exp_flush;

    initial begin
        //            ra1d  ra2d  ra1e   ra2e   wa3e  wa3m   wa3w   rwm  rww  m2r  pcd  pce  pcm  pcw  bte  fae    fbe    sf   sd   fd   fe
        vecs[0]  = '{4'd0, 4'd0, 4'd1,  4'd2,  4'd0, 4'd3,  4'd4,  1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00, 2'b00, 1'b0,1'b0,1'b0,1'b0};
        vecs[1]  = '{4'd0, 4'd0, 4'd3,  4'd15, 4'd0, 4'd3,  4'd3,  1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10, 2'b00, 1'b0,1'b0,1'b0,1'b0};
        vecs[2]  = '{4'd0, 4'd0, 4'd3,  4'd3,  4'd0, 4'd3,  4'd3,  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01, 2'b01, 1'b0,1'b0,1'b0,1'b0};
        vecs[3]  = '{4'd0, 4'd0, 4'd2,  4'd7,  4'd0, 4'd7,  4'd2,  1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01, 2'b10, 1'b0,1'b0,1'b0,1'b0};
        vecs[4]  = '{4'd0, 4'd0, 4'd5,  4'd5,  4'd0, 4'd5,  4'd5,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00, 2'b00, 1'b0,1'b0,1'b0,1'b0};
        vecs[5]  = '{4'd0, 4'd0, 4'd15, 4'd15, 4'd0, 4'd15, 4'd15, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00, 2'b00, 1'b0,1'b0,1'b0,1'b0};
        vecs[6]  = '{4'd1, 4'd5, 4'd0,  4'd0,  4'd5, 4'd0,  4'd0,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00, 2'b00, 1'b1,1'b1,1'b0,1'b1};
        vecs[7]  = '{4'd6, 4'd2, 4'd0,  4'd0,  4'd6, 4'd0,  4'd0,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00, 2'b00, 1'b1,1'b1,1'b0,1'b1};
        vecs[8]  = '{4'd1, 4'd2, 4'd0,  4'd0,  4'd6, 4'd0,  4'd0,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00, 2'b00, 1'b0,1'b0,1'b0,1'b0};
        vecs[9]  = '{4'd0, 4'd0, 4'd0,  4'd0,  4'd0, 4'd0,  4'd0,  1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00, 2'b00, 1'b1,1'b0,1'b1,1'b0};
        vecs[10] = '{4'd0, 4'd0, 4'd0,  4'd0,  4'd0, 4'd0,  4'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00, 2'b00, 1'b1,1'b0,1'b1,1'b0};
        vecs[11] = '{4'd0, 4'd0, 4'd0,  4'd0,  4'd0, 4'd0,  4'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00, 2'b00, 1'b0,1'b0,1'b1,1'b0};
        vecs[12] = '{4'd0, 4'd0, 4'd0,  4'd0,  4'd0, 4'd0,  4'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00, 2'b00, 1'b0,1'b0,1'b1,1'b1};
        vecs[13] = '{4'd9, 4'd1, 4'd0,  4'd0,  4'd9, 4'd0,  4'd0,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00, 2'b00, 1'b1,1'b1,1'b1,1'b1};
        vecs[14] = '{4'd0, 4'd0, 4'd0,  4'd0,  4'd0, 4'd0,  4'd0,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00, 2'b00, 1'b1,1'b0,1'b1,1'b0};

        // Reset state, with hazard-triggering inputs present that must be masked.
        reset_n = 1'b0;
        set_idle();
        RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3;
        MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
        #12;
        chk("reset_outputs", {21'd0, ctl_bus()}, {21'd0, RESET_BUS});
        chk("reset_timeout", {31'd0, MemTimeout}, 32'd0);
        chk("reset_stallcycles", StallCycles, 32'd0);
        chk("reset_flushcount", FlushCount, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        set_idle();
        @(negedge clk);

        // Table-driven combinational checks in RUN.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            apply_vec(vecs[i]);
            #1;
            chk($sformatf("vec%0d", i), {21'd0, ctl_bus()},
                {21'd0, vecs[i].fae, vecs[i].fbe, vecs[i].sf, vecs[i].sd, 1'b0, 1'b0,
                 vecs[i].fd, vecs[i].fe, 1'b0});
        end

        // Load-use for one cycle, then released.
        @(negedge clk);
        set_idle();
        MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
        #1;
        chk("loaduse_c0", {21'd0, ctl_bus()}, {21'd0, 11'b00_00_1100_010});
        @(negedge clk);
        MemtoRegE = 1'b0;
        #1;
        chk("loaduse_c1", {21'd0, ctl_bus()}, {21'd0, IDLE_BUS});

        // Memory wait of three cycles with a branch asserted throughout that must be ignored.
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0; BranchTakenE = 1'b1; PCSrcD = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("memwait_c%0d", c), {21'd0, ctl_bus()}, {21'd0, HOLD_BUS});
            @(negedge clk);
        end
        MemReadyM = 1'b1; BranchTakenE = 1'b0; PCSrcD = 1'b0;
        #1;
        chk("memwait_ready", {21'd0, ctl_bus()}, {21'd0, IDLE_BUS});
        @(negedge clk);
        MemReqM = 1'b0; MemReadyM = 1'b0;
        #1;
        chk("memwait_back_run", {21'd0, ctl_bus()}, {21'd0, IDLE_BUS});

        // Performance counters: 4 stall cycles then 2 branch pulses.
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (4) @(negedge clk);
        MemReadyM = 1'b1;
        @(negedge clk);
        MemReqM = 1'b0; MemReadyM = 1'b0;
        @(negedge clk);
        BranchTakenE = 1'b1;
        @(negedge clk);
        BranchTakenE = 1'b0;
        @(negedge clk);
        BranchTakenE = 1'b1;
        @(negedge clk);
        BranchTakenE = 1'b0;
        @(negedge clk);
`ifdef HAZARD_PERFCNT_EN
        exp_stall = 32'd4;
        exp_flush = 32'd2;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        chk("perf_stallcycles", StallCycles, exp_stall);
        chk("perf_flushcount", FlushCount, exp_flush);

        // Reset asserted mid-wait: counters cleared, FSM back in RUN afterwards.
        MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("midwait_holding", {21'd0, ctl_bus()}, {21'd0, HOLD_BUS});
        reset_n = 1'b0;
        #1;
        chk("midwait_reset_outputs", {21'd0, ctl_bus()}, {21'd0, RESET_BUS});
        chk("midwait_reset_stallcycles", StallCycles, 32'd0);
        chk("midwait_reset_flushcount", FlushCount, 32'd0);
        @(negedge clk);
        MemReqM = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("midwait_run_after_reset", {21'd0, ctl_bus()}, {21'd0, IDLE_BUS});

        // Watchdog: 255 waiting cycles elapse before the flag rises; it then sticks.
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (255) @(posedge clk);
        @(negedge clk);
        chk("wd_before_limit", {31'd0, MemTimeout}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("wd_at_limit", {31'd0, MemTimeout}, 32'd1);
        repeat (44) @(negedge clk);
        #1;
        chk("wd_still_waiting", {21'd0, ctl_bus()}, {21'd0, HOLD_BUS});
        MemReadyM = 1'b1;
        @(negedge clk);
        MemReqM = 1'b0; MemReadyM = 1'b0;
        repeat (3) @(negedge clk);
        chk("wd_sticky", {31'd0, MemTimeout}, 32'd1);
        chk("wd_run_after_ready", {21'd0, ctl_bus()}, {21'd0, IDLE_BUS});
        reset_n = 1'b0;
        #1;
        chk("wd_cleared_by_reset", {31'd0, MemTimeout}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
